serial_cmp_seq: RTL and testbench
=================================

Name: serial_cmp_seq

Overview:
- Bit-serial magnitude comparator controller.
- Accepts two WIDTH-bit operands through a start/busy handshake, then feeds them LSB-first (right to left) through the iterative comparison cell, one bit per clock.
- Reports the A > B result on active-low Z after exactly WIDTH run cycles.
- Sits between the operand source and any consumer of the comparison flag. It replaces the unrolled cell chain when area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to compare A and B; sampled on the rising edge of clk
- A  input  WIDTH  operand A, captured when start is accepted
- B  input  WIDTH  operand B, captured when start is accepted
- busy  output  1  high while a comparison is in progress
- done  output  1  one-cycle pulse when Z becomes valid
- Z  output  1  active-low result: 0 means A > B, 1 means A <= B; holds until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, Z = 1
  - shift registers = 0, x = 0, bit counter = 0
- State machine: IDLE, RUN, DONE.
- IDLE:
  - start=1 is accepted.
  - Latch A into sa and B into sb. Clear x to 0 and the counter to 0.
  - Go to RUN. busy rises on the next cycle.
- RUN, once per cycle:
  - x_next = (sa[0] & ~sb[0]) | (x & ~sb[0]) | (x & sa[0]).
  - Shift sa and sb right by 1. Increment the counter.
  - When the counter reaches WIDTH-1, this is the final bit: register Z = ~x_next and go to DONE.
- Starting from x=0 makes the first bit equal to the initial-cell function A0 & ~B0. No separate first-cell logic is required.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE, going straight to RUN with no bubble.
  - Otherwise go to IDLE.
- Latency: start accepted at edge 0. Bits 0..WIDTH-1 are processed at edges 1..WIDTH. Z and done are visible after edge WIDTH. Throughput is one comparison per WIDTH+1 cycles.
- busy is 1 exactly in RUN.
- start while busy=1 is ignored. Operands are not re-captured and the run is unaffected.
- A and B are don't-care except in the capture cycle.
- Z is updated only at the end of RUN. It is stable during IDLE, RUN and DONE and reflects the last completed comparison.
- Equality gives x=0, so Z=1.
- Reset asserted mid-RUN: the run is aborted immediately and every output returns to its reset value. No done pulse follows.
- Counter width is clog2(WIDTH). It never wraps within a run.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN, DONE}
  - CNT_W = clog2(WIDTH) helper
  - Z_GT constant = 1'b0, encoding the active-low "greater" level
- One natural sub-module: cmp_bit_cell.
  - Purely combinational next-state cell: inputs x, a, b; output x_next.
  - Instantiated once inside the sequencer.
- Everything else is the FSM, shift registers and counter in serial_cmp_seq.

Test Plan:
- WIDTH=8, A=0xA5, B=0x5A, start pulse -> busy high for 8 cycles, done pulse on cycle 9, Z=0.
- A=0x3C, B=0x3C -> done on cycle 9, Z=1 (equality is not greater).
- A=0x80, B=0x7F -> Z=0 (MSB overrides all lower bits). Then A=0x01, B=0x02 issued back-to-back with start in the DONE cycle -> second done exactly 9 cycles later, Z=1.
- Start held high for the entire run with A and B changing each cycle -> only the first capture is used, Z matches the first operands, no extra done.
- rst_n low at RUN cycle 4 -> busy=0, done=0, Z=1 asynchronously. After release, no done until a new start.
- Randomized 1000 operand pairs against a reference compare (A > B) -> Z == ~(A>B) on every done pulse. Busy/done timing checked each run.

Source files
------------

// File: rtl/serial_cmp_seq_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Z is active-low: Z_GT marks the "A > B" level.
package serial_cmp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic Z_GT = 1'b0;

  // Counter only has to hold WIDTH-1, so clog2(WIDTH) bits are enough.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_cmp_seq_cmp.sv
// Iterative comparison cell: carries the "A > B so far" flag up one bit.
// With x=0 on entry it reduces to the first-bit function a & ~b.
module cmp_bit_cell (
  input  logic x,
  input  logic a,
  input  logic b,
  output logic x_next
);

  assign x_next = (a & ~b) | (x & ~b) | (x & a);

endmodule

// File: rtl/serial_cmp_seq.sv
// Bit-serial A > B comparator: captures both operands on start, walks them
// LSB-first through cmp_bit_cell, and reports on active-low Z after WIDTH cycles.
module serial_cmp_seq
  import serial_cmp_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Z
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa, sb;
  logic [CNT_W-1:0] cnt;
  logic             x;
  logic             x_next;

  cmp_bit_cell u_cell (
    .x      (x),
    .a      (sa[0]),
    .b      (sb[0]),
    .x_next (x_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Z     <= 1'b1;
      sa    <= '0;
      sb    <= '0;
      x     <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        // DONE accepts a new start just like IDLE, so back-to-back runs have no bubble.
        IDLE, DONE: begin
          if (start) begin
            sa    <= A;
            sb    <= B;
            x     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          x  <= x_next;
          sa <= sa >> 1;
          sb <= sb >> 1;
          if (cnt == LAST) begin
            Z     <= ~x_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp_seq.sv
// Scoreboard bench: the driver pushes expected Z and acceptance cycle per start,
// a negedge monitor pops on every done and checks Z, done timing and busy.
module tb_serial_cmp_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         busy, done, z;

  serial_cmp_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
    .busy(busy), .done(done), .Z(z)
  );

  always #5 clk = ~clk;

  typedef struct { logic z; int acc; } exp_t;
  exp_t exp_q[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      logic bexp;
      bexp = 1'b0;
      if (exp_q.size() > 0)
        bexp = (cyc >= exp_q[0].acc) && (cyc < exp_q[0].acc + W);
      if (busy !== bexp) chk("busy", busy, bexp);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("z", z, e.z);
          chk("done_cycle", cyc, e.acc + W);
        end
      end
    end
  end

  // Call at a negedge. keep leaves start high after acceptance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic zexp, input bit keep);
    exp_t e;
    start = 1'b1; a_in = a; b_in = b;
    @(posedge clk); #1;
    e.z = zexp; e.acc = cyc;
    exp_q.push_back(e);
    if (!keep) begin
      start = 1'b0; a_in = 'x; b_in = 'x;
    end
  endtask

  // Returns at the negedge where done is visible.
  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 3*W; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    // reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_z", z, 1);
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    issue(8'hA5, 8'h5A, 1'b0, 0); wait_done();
    idle(2);
    issue(8'h3C, 8'h3C, 1'b1, 0); wait_done();
    idle(1);
    issue(8'h80, 8'h7F, 1'b0, 0); wait_done();
    // back-to-back from the DONE cycle
    issue(8'h01, 8'h02, 1'b1, 0); wait_done();
    issue(8'hFF, 8'hFE, 1'b0, 0); wait_done();
    issue(8'h00, 8'h00, 1'b1, 0); wait_done();
    issue(8'h00, 8'hFF, 1'b1, 0); wait_done();
    issue(8'h7F, 8'h80, 1'b1, 0); wait_done();
    idle(2);

    // start held with operands changing every cycle
    issue(8'h40, 8'h3F, 1'b0, 1);
    for (int i = 0; i < 3*W; i++) begin
      @(negedge clk);
      if (done) break;
      a_in = 8'h00; b_in = W'($urandom) | 8'h01;
    end
    start = 1'b0;
    idle(W + 3);
    chk("z_hold", z, 0);

    // reset mid-run after a Z=0 result
    issue(8'h10, 8'h20, 1'b1, 0);
    repeat (4) @(negedge clk);
    chk("z_stable_run", z, 0);
    exp_q.delete();
    rst_n = 1'b0; #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_z", z, 1);
    @(negedge clk); rst_n = 1'b1;
    idle(2 * W);

    // random pairs against a reference compare
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      if (i % 7 == 0) rb = ra;
      issue(ra, rb, ~(ra > rb), 0);
      wait_done();
      if (i % 3 == 0) idle(1);
    end
    idle(4);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
